// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared types, widths and helpers for the reset sequencer
package reset_seq_pkg;
  typedef enum logic [1:0] {ASSERT, WAIT, DONE, FAULT} state_e;
  localparam int ERR_STAGE_W = 4;
  // Width of a down-counter that must hold max(hold, timeout)-1; at least 1 bit.
  function automatic int timer_width(input int hold, input int timeout);
    int m;
    m = (hold > timeout) ? hold : timeout;
    return (m > 2) ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/seq_timer.sv
// seq_timer: loadable saturating down-counter with enable and zero flag
// Ports: clk, reset_n (async active-low), en (cycle qualifier), load (strobe),
//        load_val (value taken on load), zero (count is 0).
module seq_timer #(
  parameter int W = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= RST_VAL;
    else if (en) cnt_q <= cnt_d;
  end
  assign zero = (cnt_q == '0);
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: ordered release of NUM_STAGES reset domains with hold time and per-stage timeout
// Ports: clk, reset_n (async active-low), enable (cycle qualifier), soft_reset (sync restart),
//        stage_ready (per-stage lock, synchronous), stage_reset (per-stage active-high reset),
//        done (all released and ready), error (a stage timed out), error_stage (timed-out index).
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES     = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   soft_reset,
  input  logic [NUM_STAGES-1:0]  stage_ready,
  output logic [NUM_STAGES-1:0]  stage_reset,
  output logic                   done,
  output logic                   error,
  output logic [ERR_STAGE_W-1:0] error_stage
);
  localparam int TW = timer_width(HOLD_CYCLES, TIMEOUT_CYCLES);
  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TO_LD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_STAGES-1:0] ALL = '1;
  localparam logic [ERR_STAGE_W-1:0] LAST = ERR_STAGE_W'(NUM_STAGES - 1);
  state_e                 state_q, state_d;
  logic [ERR_STAGE_W-1:0] idx_q, idx_d, error_stage_q, error_stage_d;
  logic [NUM_STAGES-1:0]  stage_reset_q, stage_reset_d;
  logic                   done_q, done_d, error_q, error_d;
  logic                   tmr_load, tmr_zero, cur_ready, lost_wait, lost;
  logic [TW-1:0]          tmr_val;
  seq_timer #(.W(TW), .RST_VAL(HOLD_LD)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (enable),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );
  // Only the stage under release and those already released are observed.
  always_comb begin
    cur_ready = 1'b0;
    lost_wait = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      cur_ready |= stage_ready[i] & (idx_q == ERR_STAGE_W'(i));
      lost_wait |= ~stage_ready[i] & (ERR_STAGE_W'(i) < idx_q);
    end
    lost = (state_q == WAIT && lost_wait) || (state_q == DONE && !(&stage_ready));
  end
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    stage_reset_d = stage_reset_q;
    done_d        = done_q;
    error_d       = error_q;
    error_stage_d = error_stage_q;
    tmr_load      = 1'b0;
    tmr_val       = HOLD_LD;
    if (soft_reset || lost) begin
      state_d       = ASSERT;
      idx_d         = '0;
      stage_reset_d = ALL;
      done_d        = 1'b0;
      error_d       = 1'b0;
      error_stage_d = '0;
      tmr_load      = 1'b1;
    end else begin
      case (state_q)
        ASSERT: if (tmr_zero) begin
          state_d       = WAIT;
          idx_d         = '0;
          stage_reset_d = ALL << 1;
          tmr_load      = 1'b1;
          tmr_val       = TO_LD;
        end
        WAIT: if (cur_ready && idx_q == LAST) begin
          state_d       = DONE;
          stage_reset_d = '0;
          done_d        = 1'b1;
        end else if (cur_ready) begin
          idx_d         = idx_q + 1'b1;
          stage_reset_d = ALL << (idx_q + 4'd2);
          tmr_load      = 1'b1;
          tmr_val       = TO_LD;
        end else if (tmr_zero) begin
          state_d       = FAULT;
          stage_reset_d = ALL;
          error_d       = 1'b1;
          error_stage_d = idx_q;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ASSERT;
      idx_q         <= '0;
      stage_reset_q <= ALL;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      error_stage_q <= '0;
    end else if (enable) begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      stage_reset_q <= stage_reset_d;
      done_q        <= done_d;
      error_q       <= error_d;
      error_stage_q <= error_stage_d;
    end
  end
  assign stage_reset = stage_reset_q;
  assign done        = done_q;
  assign error       = error_q;
  assign error_stage = error_stage_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed and randomized checks of reset_sequencer against a behavioural model
module tb_reset_sequencer;
  localparam int NS = 4;
  localparam int H  = 16;
  localparam int T  = 8;
  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b1;
  logic          soft_reset = 1'b0;
  logic [NS-1:0] stage_ready = '1;
  logic [NS-1:0] stage_reset;
  logic          done, error;
  logic [3:0]    error_stage;
  int checks = 0;
  int errors = 0;
  reset_sequencer #(.NUM_STAGES(NS), .HOLD_CYCLES(H), .TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .soft_reset  (soft_reset),
    .stage_ready (stage_ready),
    .stage_reset (stage_reset),
    .done        (done),
    .error       (error),
    .error_stage (error_stage)
  );
  always #5 clk = ~clk;
  // Model: phase 0 holding, 1 releasing (m_n stages released), 2 done, 3 fault.
  // m_el counts enabled edges spent in the current hold or wait.
  int m_phase = 0;
  int m_n = 0;
  int m_el = 0;
  int m_fs = 0;
  always @(negedge reset_n) begin
    m_phase = 0;
    m_n = 0;
    m_el = 0;
  end
  always @(posedge clk) if (reset_n && enable) begin
    bit lost;
    lost = 0;
    if (m_phase == 1) for (int i = 0; i < m_n - 1; i++) if (!stage_ready[i]) lost = 1;
    if (m_phase == 2 && stage_ready != 4'hF) lost = 1;
    if (soft_reset || lost) begin
      m_phase = 0; m_n = 0; m_el = 0;
    end else if (m_phase == 0) begin
      m_el++;
      if (m_el == H) begin m_phase = 1; m_n = 1; m_el = 0; end
    end else if (m_phase == 1) begin
      if (stage_ready[m_n-1]) begin
        if (m_n == NS) m_phase = 2;
        else begin m_n++; m_el = 0; end
      end else begin
        m_el++;
        if (m_el == T) begin m_phase = 3; m_fs = m_n - 1; end
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    logic [3:0] e_sr;
    e_sr = (m_phase == 1) ? (4'hF << m_n) : (m_phase == 2 ? 4'h0 : 4'hF);
    chk("model_stage_reset", 32'(stage_reset), 32'(e_sr));
    chk("model_done", 32'(done), 32'(m_phase == 2));
    chk("model_error", 32'(error), 32'(m_phase == 3));
    chk("model_error_stage", 32'(error_stage), (m_phase == 3) ? 32'(m_fs) : 0);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic step_until_sr(input logic [3:0] v);
    int i;
    i = 0;
    while (stage_reset !== v && i < 200) begin step(); i++; end
    chk("wait_stage_reset", 32'(stage_reset), 32'(v));
  endtask
  task automatic soft_pulse();
    soft_reset = 1'b1;
    step();
    soft_reset = 1'b0;
  endtask
  initial begin
    int cnt, guard;
    repeat (3) step();
    chk("reset_sr", 32'(stage_reset), 32'hF);
    chk("reset_done", 32'(done), 0);
    chk("reset_err", 32'(error), 0);
    chk("reset_es", 32'(error_stage), 0);
    reset_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (e == 15) chk("e15_sr", 32'(stage_reset), 32'hF);
      if (e == 16) chk("e16_sr", 32'(stage_reset), 32'hE);
      if (e == 17) chk("e17_sr", 32'(stage_reset), 32'hC);
      if (e == 18) chk("e18_sr", 32'(stage_reset), 32'h8);
      if (e == 19) begin chk("e19_sr", 32'(stage_reset), 0); chk("e19_done", 32'(done), 0); end
      if (e == 20) chk("e20_done", 32'(done), 1);
    end
    stage_ready = 4'b1011;
    soft_pulse();
    step_until_sr(4'b1000);
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 7) chk("to_k7_err", 32'(error), 0);
    end
    chk("to_err", 32'(error), 1);
    chk("to_es", 32'(error_stage), 2);
    chk("to_sr", 32'(stage_reset), 32'hF);
    chk("to_done", 32'(done), 0);
    stage_ready = 4'hF;
    soft_pulse();
    chk("soft_err", 32'(error), 0);
    chk("soft_sr", 32'(stage_reset), 32'hF);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 19) chk("soft_k19_done", 32'(done), 0);
    end
    chk("soft_k20_done", 32'(done), 1);
    stage_ready = 4'b1101;
    step();
    stage_ready = 4'hF;
    chk("loss_sr", 32'(stage_reset), 32'hF);
    chk("loss_done", 32'(done), 0);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 19) chk("loss_k19_done", 32'(done), 0);
    end
    chk("loss_k20_done", 32'(done), 1);
    stage_ready = 4'b0001;
    soft_pulse();
    step_until_sr(4'b1100);
    repeat (7) step();
    chk("edge_pre_err", 32'(error), 0);
    stage_ready = 4'b0011;
    step();
    chk("edge_err", 32'(error), 0);
    chk("edge_sr", 32'(stage_reset), 32'h8);
    stage_ready = 4'hF;
    soft_pulse();
    cnt = 0;
    guard = 0;
    while (cnt < 20 && guard < 400) begin
      enable = 1'($urandom_range(0, 1));
      step();
      guard++;
      if (enable) begin
        cnt++;
        if (cnt == 19) chk("en_e19_done", 32'(done), 0);
      end
    end
    chk("en_e20_done", 32'(done), 1);
    enable = 1'b1;
    stage_ready = 4'b0001;
    soft_pulse();
    step_until_sr(4'b1100);
    #2 reset_n = 1'b0;
    #1 chk("async_sr", 32'(stage_reset), 32'hF);
    chk("async_done", 32'(done), 0);
    step();
    reset_n = 1'b1;
    stage_ready = 4'hF;
    soft_pulse();
    for (int c = 0; c < 3000; c++) begin
      enable = ($urandom_range(0, 7) != 0);
      soft_reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 15) == 0)
        stage_ready = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
